// File: rtl/hps_tile_reader.sv
// Purpose: HPS tile responder; fetches TILE_N consecutive frame words at (row, col) into a flat tile register.
// Latency: 1 cycle address setup, then TILE_N+1 cycles minimum (GNT=1, 1-cycle data) to DONE; start/done 4-phase.
// Backpressure: requests stall while iMEM_GNT is low; responses accepted whenever iMEM_VALID in FETCH.
// Build option: define HPS_TILE_CLAMP_EN to clamp column overflow to the last pixel instead of erroring.
module hps_tile_reader #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int TILE_N    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     iSTART,
    input  logic [9:0]               iROW,
    input  logic [9:0]               iCOL,
    output logic                     oMEM_REQ,
    output logic [ADDR_W-1:0]        oMEM_ADDR,
    input  logic                     iMEM_GNT,
    input  logic                     iMEM_VALID,
    input  logic [DATA_W-1:0]        iMEM_DATA,
    output logic [TILE_N*DATA_W-1:0] oTILE,
    output logic                     oBUSY,
    output logic                     oDONE,
    output logic                     oERR,
    output logic [1:0]               oSTATE
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] TILE_CNT  = CNT_W'(TILE_N);
    localparam logic [CNT_W-1:0] TILE_LAST = CNT_W'(TILE_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        row_addr;
    logic [9:0]               col_r;
    logic [CNT_W-1:0]         req_cnt;
    logic [CNT_W-1:0]         rsp_cnt;
    logic [TILE_N*DATA_W-1:0] tile;

    logic [31:0]       row_ext, col_ext, col_k, col_eff;
    logic              row_bad, col_bad, start_err, start_ok;
    logic              mem_req, rsp_take;
    logic [ADDR_W-1:0] mem_addr;

    assign row_ext = {22'd0, iROW};
    assign col_ext = {22'd0, iCOL};
    assign row_bad = row_ext >= 32'(IMG_H);
    assign col_bad = (col_ext + 32'(TILE_N)) > 32'(IMG_W);

`ifdef HPS_TILE_CLAMP_EN
    assign start_err = row_bad;
`else
    assign start_err = row_bad | col_bad;
`endif

    assign start_ok = (state == S_IDLE) && iSTART && !start_err;

    // Column of the current request; with clamping, overflow repeats the last pixel of the line.
    assign col_k = {22'd0, col_r} + {27'd0, req_cnt};
`ifdef HPS_TILE_CLAMP_EN
    assign col_eff = (col_k > 32'(IMG_W - 1)) ? 32'(IMG_W - 1) : col_k;
`else
    assign col_eff = col_k;
`endif

    assign mem_addr = row_addr + col_eff[ADDR_W-1:0];
    assign mem_req  = (state == S_FETCH) && (req_cnt < TILE_CNT);
    assign rsp_take = (state == S_FETCH) && iMEM_VALID && (rsp_cnt < TILE_CNT);

    assign oMEM_REQ  = mem_req;
    assign oMEM_ADDR = mem_req ? mem_addr : '0;
    assign oTILE     = tile;
    assign oBUSY     = (state == S_FETCH);
    assign oDONE     = (state == S_DONE);
    assign oERR      = (state == S_ERR);
    assign oSTATE    = state;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: start request, completion on the last response, release on start low.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (iSTART) state_nxt = start_err ? S_ERR : S_FETCH;
            S_FETCH: if (rsp_take && rsp_cnt == TILE_LAST) state_nxt = S_DONE;
            S_DONE:  if (!iSTART) state_nxt = S_IDLE;
            S_ERR:   if (!iSTART) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the registered row base and column on start; count grants and responses during the fetch.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            row_addr <= '0;
            col_r    <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
        end else if (start_ok) begin
            row_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(row_ext * 32'(IMG_W));
            col_r    <= iCOL;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
        end else begin
            if (mem_req && iMEM_GNT) req_cnt <= req_cnt + 1'b1;
            if (rsp_take)            rsp_cnt <= rsp_cnt + 1'b1;
        end
    end

    // Write each in-order response into its slot; untouched slots keep their previous data.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tile <= '0;
        end else if (rsp_take) begin
            for (int k = 0; k < TILE_N; k++) begin
                if (rsp_cnt == CNT_W'(k)) tile[k*DATA_W +: DATA_W] <= iMEM_DATA;
            end
        end
    end

endmodule

// File: tb/tb_hps_tile_reader.sv
// Purpose: randomized scoreboard bench for hps_tile_reader against a behavioural tile/address model.
// Latency: checks start-to-done latency on an unstalled fetch; all waits are cycle-bounded.
// Backpressure: memory model drives random grants and random 1..4 cycle in-order data latency.
module tb_hps_tile_reader;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int IMG_W  = 640;
    localparam int IMG_H  = 480;
    localparam int TILE_N = 16;
`ifdef HPS_TILE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic                     iCLK = 1'b0;
    logic                     iRST_N = 1'b0;
    logic                     iSTART = 1'b0;
    logic [9:0]               iROW = '0;
    logic [9:0]               iCOL = '0;
    logic                     oMEM_REQ;
    logic [ADDR_W-1:0]        oMEM_ADDR;
    logic                     iMEM_GNT = 1'b0;
    logic                     iMEM_VALID;
    logic [DATA_W-1:0]        iMEM_DATA;
    logic [TILE_N*DATA_W-1:0] oTILE;
    logic                     oBUSY, oDONE, oERR;
    logic [1:0]               oSTATE;

    hps_tile_reader dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iROW(iROW), .iCOL(iCOL),
        .oMEM_REQ(oMEM_REQ), .oMEM_ADDR(oMEM_ADDR), .iMEM_GNT(iMEM_GNT),
        .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA), .oTILE(oTILE),
        .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR), .oSTATE(oSTATE)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct { logic err; logic [255:0] tile; } exp_t;
    exp_t              exp_q[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [ADDR_W-1:0] rq_addr[$];
    int                rq_due[$];
    int                cyc = 0;
    int                last_due = 0;
    int                gnt_pct = 100;
    int                max_lat = 1;
    int                grant_cnt = 0;
    int                req_cycles = 0;
    logic              mdl_vld = 1'b0;
    logic [15:0]       mdl_dat = '0;
    logic              stray_vld = 1'b0;
    logic [15:0]       stray_dat = '0;
    logic [255:0]      last_tile = '0;

    assign iMEM_VALID = mdl_vld | stray_vld;
    assign iMEM_DATA  = mdl_vld ? mdl_dat : stray_dat;

    // Drives grant and data for the coming edge; data is addr[15:0], returned in order.
    always @(negedge iCLK) begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] e;
        int due;
        cyc++;
        if (!iRST_N) begin
            rq_addr.delete();
            rq_due.delete();
            mdl_vld  = 1'b0;
            iMEM_GNT = 1'b0;
        end else begin
            iMEM_GNT = ($urandom_range(99) < gnt_pct);
            if (oMEM_REQ) req_cycles++;
            if (oMEM_REQ && iMEM_GNT) begin
                grant_cnt++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_grant got addr %0d want no request", oMEM_ADDR);
                end else begin
                    e = exp_addr.pop_front();
                    chk("req_addr", 256'(oMEM_ADDR), 256'(e));
                end
                due = cyc + $urandom_range(max_lat, 1);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rq_addr.push_back(oMEM_ADDR);
                rq_due.push_back(due);
            end
            if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
                a = rq_addr.pop_front();
                void'(rq_due.pop_front());
                mdl_vld = 1'b1;
                mdl_dat = a[15:0];
            end else begin
                mdl_vld = 1'b0;
            end
        end
    end

    // Monitor: on each DONE/ERR entry, compare against the oldest expectation.
    logic prev_fin = 1'b0;
    always @(negedge iCLK) begin
        exp_t e;
        if (!iRST_N) begin
            prev_fin = 1'b0;
        end else begin
            if ((oDONE || oERR) && !prev_fin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion got state %0d want no completion", oSTATE);
                end else begin
                    e = exp_q.pop_front();
                    chk("fin_err", 256'(oERR), 256'(e.err));
                    chk("fin_done", 256'(oDONE), 256'(!e.err));
                    chk("fin_tile", oTILE, e.tile);
                end
            end
            prev_fin = oDONE || oERR;
        end
    end

    // Reference: expected addresses and resulting tile computed from the frame geometry.
    task automatic expect_fetch(input int row, input int col, output bit is_err);
        exp_t e;
        int   c;
        int   a;
        is_err = (row >= IMG_H) || (!CLAMP && (col + TILE_N > IMG_W));
        e.err  = is_err;
        e.tile = last_tile;
        if (!is_err) begin
            for (int k = 0; k < TILE_N; k++) begin
                c = col + k;
                if (CLAMP && c > IMG_W - 1) c = IMG_W - 1;
                a = row * IMG_W + c;
                exp_addr.push_back(ADDR_W'(a));
                e.tile[k*16 +: 16] = 16'(a);
            end
        end
        last_tile = e.tile;
        exp_q.push_back(e);
    endtask

    // Issue one start, wait for DONE/ERR (bounded), hold start, release and check IDLE.
    task automatic run_fetch(input int row, input int col, input int hold, output int lat);
        bit is_err;
        int rc0;
        expect_fetch(row, col, is_err);
        @(posedge iCLK); #1;
        iROW   = 10'(row);
        iCOL   = 10'(col);
        iSTART = 1'b1;
        lat    = 0;
        while (1) begin
            @(posedge iCLK); #1;
            lat++;
            if (oDONE || oERR) break;
            if (lat > 2000) begin
                checks++;
                errors++;
                $display("FAIL fetch_timeout got %0d cycles want completion", lat);
                exp_q.delete();
                exp_addr.delete();
                break;
            end
        end
        rc0 = req_cycles;
        repeat (hold) @(posedge iCLK);
        #1;
        if (hold > 0) begin
            chk("hold_state", 256'(oSTATE), is_err ? 256'(3) : 256'(2));
            chk("hold_no_req", 256'(req_cycles - rc0), 256'(0));
        end
        iSTART = 1'b0;
        @(posedge iCLK); #1;
        chk("release_idle", 256'(oSTATE), 256'(0));
    endtask

    initial begin
        int lat;
        int rc0;
        int g0;
        int n;

        // Reset state.
        #12;
        chk("rst_state", 256'(oSTATE), 256'(0));
        chk("rst_outs", 256'({oMEM_REQ, oBUSY, oDONE, oERR}), 256'(0));
        chk("rst_addr", 256'(oMEM_ADDR), 256'(0));
        chk("rst_tile", oTILE, 256'(0));
        @(posedge iCLK); #2;
        iRST_N = 1'b1;

        // Basic unstalled fetch: latency and request count.
        gnt_pct = 100;
        max_lat = 1;
        rc0 = req_cycles;
        run_fetch(2, 16, 0, lat);
        chk("basic_latency", 256'(lat), 256'(TILE_N + 2));
        chk("basic_req_cycles", 256'(req_cycles - rc0), 256'(TILE_N));

        // Backpressure at the bottom-right tile.
        gnt_pct = 50;
        max_lat = 4;
        g0 = grant_cnt;
        run_fetch(479, 624, 2, lat);
        chk("bp_grants", 256'(grant_cnt - g0), 256'(TILE_N));

        // Range checks: column overflow and row overflow.
        rc0 = req_cycles;
        run_fetch(0, 630, 3, lat);
        chk("col630_req_cycles", 256'(req_cycles - rc0), CLAMP ? 256'(TILE_N) : 256'(0));
        rc0 = req_cycles;
        run_fetch(480, 0, 2, lat);
        chk("row480_req_cycles", 256'(req_cycles - rc0), 256'(0));

        // Long hold after DONE must not retrigger.
        gnt_pct = 100;
        max_lat = 2;
        run_fetch(10, 100, 50, lat);

        // Stray valid in IDLE must not write the tile.
        @(negedge iCLK);
        stray_dat = 16'hBEEF;
        stray_vld = 1'b1;
        @(negedge iCLK);
        stray_vld = 1'b0;
        @(posedge iCLK); #1;
        chk("stray_tile", oTILE, last_tile);

        // Reset after five grants.
        gnt_pct = 70;
        max_lat = 3;
        begin
            bit is_err;
            expect_fetch(100, 200, is_err);
            void'(exp_q.pop_back());
        end
        g0 = grant_cnt;
        @(posedge iCLK); #1;
        iROW   = 10'd100;
        iCOL   = 10'd200;
        iSTART = 1'b1;
        n = 0;
        while (grant_cnt - g0 < 5 && n < 500) begin
            @(posedge iCLK); #1;
            n++;
        end
        chk("rst_mid_grants", 256'(grant_cnt - g0), 256'(5));
        iRST_N = 1'b0;
        iSTART = 1'b0;
        #1;
        chk("rst_mid_state", 256'(oSTATE), 256'(0));
        chk("rst_mid_outs", 256'({oMEM_REQ, oBUSY, oDONE, oERR}), 256'(0));
        chk("rst_mid_addr", 256'(oMEM_ADDR), 256'(0));
        chk("rst_mid_tile", oTILE, 256'(0));
        exp_addr.delete();
        last_tile = '0;
        repeat (3) @(posedge iCLK);
        #2;
        iRST_N = 1'b1;
        run_fetch(0, 0, 1, lat);

        // Randomized fetches, including out-of-range coordinates.
        for (int i = 0; i < 24; i++) begin
            int r;
            int c;
            gnt_pct = $urandom_range(100, 30);
            max_lat = $urandom_range(4, 1);
            r = ($urandom_range(9) == 0) ? $urandom_range(520, 480) : $urandom_range(IMG_H - 1);
            c = ($urandom_range(3) == 0) ? $urandom_range(IMG_W - 1, 600) : $urandom_range(IMG_W - TILE_N);
            run_fetch(r, c, $urandom_range(3), lat);
        end

        repeat (5) @(posedge iCLK);
        #1;
        chk("drain_exp", 256'(exp_q.size()), 256'(0));
        chk("drain_addr", 256'(exp_addr.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hps_tile_reader.md
Name: hps_tile_reader

Overview:
Responder for the HPS pixel-fetch PIO interface: start/state/row/col in, imgdata words out. On an HPS start request it reads TILE_N consecutive 16-bit frame-buffer words at (row, col) through a generic in-order memory read port. It packs them into a flat tile register for the imgdata PIOs and completes a 4-phase start/done handshake. Sits between the SDRAM read-port arbiter and the mysystem PIO exports.

Parameters:
ADDR_W, 22, memory word-address width
DATA_W, 16, memory/pixel word width
IMG_W, 640, frame width in words
IMG_H, 480, frame height in lines
TILE_N, 16, words per tile (2..16)
BASE_ADDR, 0, frame start word address

Ports:
iCLK  in  1  system clock; all logic on rising edge
iRST_N  in  1  asynchronous active-low reset
iSTART  in  1  HPS start level, synchronous to iCLK
iROW  in  10  tile row
iCOL  in  10  tile first column
oMEM_REQ  out  1  read request
oMEM_ADDR  out  ADDR_W  request word address
iMEM_GNT  in  1  request accepted this cycle when oMEM_REQ=1
iMEM_VALID  in  1  read data valid; responses return in request order
iMEM_DATA  in  DATA_W  read data
oTILE  out  TILE_N*DATA_W  word k at bits [k*DATA_W +: DATA_W]
oBUSY  out  1  high in FETCH
oDONE  out  1  high in DONE
oERR  out  1  high in ERR
oSTATE  out  2  IDLE=0, FETCH=1, DONE=2, ERR=3

Behaviour:
- Reset values: state IDLE; oMEM_REQ=0; oMEM_ADDR=0; oTILE=0; oBUSY/oDONE/oERR=0; oSTATE=0; counters 0.
- IDLE, iSTART=1: latch iROW/iCOL.
  - Range check: row>=IMG_H or col+TILE_N>IMG_W -> ERR. No memory request is issued.
  - Otherwise register start address BASE_ADDR + row*IMG_W + col, then enter FETCH. The product is registered, so 1 cycle from IDLE to FETCH.
- FETCH:
  - oMEM_REQ=1 while req_cnt<TILE_N; oMEM_ADDR = start + req_cnt.
  - req_cnt increments on REQ&GNT.
  - Each iMEM_VALID writes iMEM_DATA into slot rsp_cnt, then rsp_cnt increments. Requests and responses may overlap; a same-cycle grant and valid both count.
  - When rsp_cnt reaches TILE_N (last valid cycle) -> DONE next cycle; oMEM_REQ is already 0.
  - Minimum latency with GNT always high and data 1 cycle after grant: TILE_N+2 cycles from start detect to oDONE.
- DONE / ERR: hold until iSTART=0, then -> IDLE. iSTART staying high does not retrigger.
- oTILE holds its value through DONE, IDLE and ERR.
  - A new fetch overwrites slots in order; slots not yet rewritten keep old data until written.
  - ERR leaves oTILE unchanged.
- iMEM_VALID outside FETCH, or after rsp_cnt=TILE_N, is ignored; no slot is written.
- Reset mid-FETCH: immediate return to IDLE and all outputs to reset values. The arbiter is reset by the same iRST_N.
- Address arithmetic is done at ADDR_W width; the range check guarantees no wrap.
- iSTART high during FETCH has no effect.

Optional Feature:
HPS_TILE_CLAMP_EN
- Defined:
  - Column overflow (col+TILE_N>IMG_W) is not an error.
  - Request k uses column min(col+k, IMG_W-1), so the last valid pixel repeats.
  - col>=IMG_W is clamped the same way; every request addresses IMG_W-1.
  - row>=IMG_H still -> ERR.
- Undefined: behaviour exactly as above. Column overflow -> ERR, no requests issued.

Test Plan:
- Basic fetch: memory model returns data=addr[15:0], GNT=1, 1-cycle latency; iROW=2, iCOL=16 -> addresses 1296..1311 in order. oTILE word k = 1296+k. oDONE rises TILE_N+2 cycles after iSTART; iSTART=0 -> oSTATE=0 next cycle.
- Backpressure: GNT random 50%, data latency 1..4 cycles, iROW=479, iCOL=624 -> exactly 16 grants, addresses 307184..307199, correct tile, no extra REQ after 16th grant.
- Range error: iCOL=630 -> oERR=1, oSTATE=3, zero oMEM_REQ cycles, oTILE unchanged. iROW=480 -> ERR. iSTART low -> IDLE.
- Handshake: hold iSTART high 50 cycles after DONE -> single fetch only. Stray iMEM_VALID in IDLE with data 0xBEEF -> oTILE unchanged.
- Reset mid-FETCH: assert iRST_N=0 after 5 grants -> all outputs 0 asynchronously. After release, a new fetch at (0,0) completes with words 0..15.
- With HPS_TILE_CLAMP_EN, iROW=0, iCOL=630 -> addresses 630..639 then 639 ×6, oDONE=1, oERR=0.
